// File: rtl/word_unpacker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : word_unpacker_pkg
//  Description : Shared constants, state type and helpers for word_unpacker.
//  Revision    : 1.0 - initial release
// ============================================================================
package word_unpacker_pkg;

    localparam int DEF_BYTE_W = 8;
    localparam int DEF_LANES  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // Lane-index width: never narrower than one bit, even for a single lane.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_unpacker_rep_detect.sv
`default_nettype none
// ============================================================================
//  Module      : rep_detect
//  Description : Combinational check that a word is {LANES{lane0}}.
//  Revision    : 1.0 - initial release
// ============================================================================
module rep_detect
    import word_unpacker_pkg::*;
#(
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic [LANES*BYTE_W-1:0] word_i,
    output logic                    rep_o,
    output logic [BYTE_W-1:0]       lane0_o
);

    logic [LANES-1:0] w_eq;

    assign lane0_o = word_i[BYTE_W-1:0];
    assign w_eq[0] = 1'b1;

    // Compare every higher lane against lane 0.
    for (genvar k = 1; k < LANES; k++) begin : g_cmp
        assign w_eq[k] = (word_i[k*BYTE_W +: BYTE_W] == word_i[BYTE_W-1:0]);
    end

    assign rep_o = &w_eq;

endmodule
`default_nettype wire

// File: rtl/word_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : word_unpacker
//  Description : Splits a LANES*BYTE_W word into BYTE_W beats, lane 0 first;
//                replicated words may be collapsed to a single beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_unpacker
    import word_unpacker_pkg::*;
#(
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int LANES  = DEF_LANES,
    localparam int LW    = lane_idx_w(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*BYTE_W-1:0] in_data,
    input  logic                    compress,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W-1:0]       out_data,
    output logic [LW-1:0]           out_lane,
    output logic                    out_last,
    output logic                    out_rep
);

    localparam logic [LW-1:0] c_LAST_LANE = LW'(LANES - 1);

    state_e                    state_q, state_d;
    logic [LANES*BYTE_W-1:0]   word_q,  word_d;
    logic [LW-1:0]             lane_q,  lane_d;
    logic                      comp_q,  comp_d;
    logic                      rep_q,   rep_d;

    logic                      w_rep;
    logic [BYTE_W-1:0]         w_lane0;
    logic                      w_in_xfer;
    logic                      w_out_xfer;
    logic [BYTE_W-1:0]         w_lanes [LANES];

    rep_detect #(
        .BYTE_W (BYTE_W),
        .LANES  (LANES)
    ) u_rep_detect (
        .word_i  (in_data),
        .rep_o   (w_rep),
        .lane0_o (w_lane0)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lanes
        assign w_lanes[k] = word_q[k*BYTE_W +: BYTE_W];
    end

    // Output view of the held word; everything reads zero while idle.
    always_comb begin
        out_valid = (state_q == ST_EMIT);
        out_lane  = out_valid ? lane_q : '0;
        out_data  = out_valid ? w_lanes[lane_q] : '0;
        out_last  = out_valid && ((lane_q == c_LAST_LANE) || comp_q);
        out_rep   = rep_q;
        in_ready  = (state_q == ST_IDLE) || (out_valid && out_ready && out_last);
    end

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Next-state: load on input transfer, step lanes on output transfer.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        comp_d  = comp_q;
        rep_d   = rep_q;
        if (w_in_xfer) begin
            state_d = ST_EMIT;
            // A collapsed word is rebuilt from lane 0 so the held value is canonical.
            word_d  = (compress && w_rep) ? {LANES{w_lane0}} : in_data;
            lane_d  = '0;
            comp_d  = compress && w_rep;
            rep_d   = w_rep;
        end else if (w_out_xfer) begin
            if (out_last) begin
                state_d = ST_IDLE;
                lane_d  = '0;
                comp_d  = 1'b0;
                rep_d   = 1'b0;
            end else begin
                lane_d  = lane_q + LW'(1);
            end
        end
    end

    // State and holding registers; reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            lane_q  <= '0;
            comp_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            comp_q  <= comp_d;
            rep_q   <= rep_d;
        end
    end

endmodule
`default_nettype wire
